// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the I$/D$ miss arbiter: request payload, bus widths and arbiter FSM encoding.
package mem_req_arbiter_pkg;

    localparam int THR_PER_CORE       = 4;
    localparam int THR_PER_CORE_WIDTH = $clog2(THR_PER_CORE);
    localparam int DCACHE_LINE_WIDTH  = 128;
    localparam int MEM_ADDR_WIDTH     = 32;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0]     addr;
        logic [DCACHE_LINE_WIDTH-1:0]  data;
        logic                          is_store;
        logic [THR_PER_CORE_WIDTH-1:0] thread_id;
    } memory_request_t;

    typedef logic [1:0] mem_arb_state_t;

    localparam mem_arb_state_t ARB_IDLE  = 2'd0;
    localparam mem_arb_state_t ARB_ISSUE = 2'd1;
    localparam mem_arb_state_t ARB_WAIT  = 2'd2;

    localparam logic CACHE_ID_I = 1'b0;
    localparam logic CACHE_ID_D = 1'b1;

endpackage

// File: rtl/mem_req_arbiter_fifo.sv
// Per-cache miss queue. The head falls through from the write port when empty so a request
// can be granted in the same cycle it is pushed; overflow pulses when a push is dropped.
module mem_req_arbiter_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1'b1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             empty_s;
    logic             full_s;
    logic             bypass_s;
    logic             wr_en_s;
    logic             rd_en_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return '0;
        end else begin
            return ptr + PTR_ONE;
        end
    endfunction

    assign empty_s  = (count_r == '0);
    assign full_s   = (count_r == CNT_FULL);
    // A push consumed by a same-cycle pop on an empty queue never touches storage.
    assign bypass_s = empty_s && push && pop;
    assign wr_en_s  = push && !bypass_s && (!full_s || pop);
    assign rd_en_s  = pop && !empty_s;
    assign overflow = push && full_s && !pop;

    // Head selection with fall-through from the write port
    always_comb begin
        head_valid = !empty_s || push;
        if (empty_s) begin
            head_data = push_data;
        end else begin
            head_data = mem_r[rd_ptr_r];
        end
    end

    // Entry storage
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (rd_en_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates I$ and D$ miss queues onto the single main-memory port, one transaction at a
// time, and routes each response back to its cache and thread.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int QUEUE_DEPTH  = THR_PER_CORE,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          icache_req_valid,
    input  memory_request_t               icache_req_info,
    input  logic                          dcache_req_valid,
    input  memory_request_t               dcache_req_info,
    output logic                          mm_req_valid,
    output memory_request_t               mm_req_info,
    input  logic                          mm_req_ready,
    input  logic                          mm_rsp_valid,
    input  logic [DCACHE_LINE_WIDTH-1:0]  mm_rsp_data,
    input  logic                          mm_rsp_bus_error,
    output logic                          rsp_valid_miss,
    output logic                          rsp_cache_id,
    output logic [THR_PER_CORE_WIDTH-1:0] rsp_thread_id,
    output logic [DCACHE_LINE_WIDTH-1:0]  rsp_data_miss,
    output logic                          rsp_bus_error,
    output logic                          overflow_error
);

    localparam int REQ_W    = $bits(memory_request_t);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1'b1);

    logic                ivalid_s;
    logic                dvalid_s;
    logic [REQ_W-1:0]    ihead_s;
    logic [REQ_W-1:0]    dhead_s;
    logic                iovf_s;
    logic                dovf_s;
    logic                grant_i_s;
    logic                grant_d_s;
    logic                rsp_fire_s;
    memory_request_t     winner_s;
    mem_arb_state_t      state_r;
    mem_arb_state_t      state_nxt_s;
    logic [STARVE_W-1:0] starve_cnt_r;
    logic [STARVE_W-1:0] starve_nxt_s;
    logic                cache_id_r;

    mem_req_arbiter_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_icache_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (icache_req_valid),
        .push_data  (icache_req_info),
        .pop        (grant_i_s),
        .head_valid (ivalid_s),
        .head_data  (ihead_s),
        .overflow   (iovf_s)
    );

    mem_req_arbiter_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_dcache_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (dcache_req_valid),
        .push_data  (dcache_req_info),
        .pop        (grant_d_s),
        .head_valid (dvalid_s),
        .head_data  (dhead_s),
        .overflow   (dovf_s)
    );

    assign rsp_fire_s = (state_r == ARB_WAIT) && mm_rsp_valid;

    // Winner selection and FSM next-state decode; D$ is preferred until I$ has starved
    always_comb begin
        state_nxt_s = state_r;
        grant_i_s   = 1'b0;
        grant_d_s   = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (dvalid_s && !(ivalid_s && (starve_cnt_r == STARVE_MAX))) begin
                    grant_d_s   = 1'b1;
                    state_nxt_s = ARB_ISSUE;
                end else if (ivalid_s) begin
                    grant_i_s   = 1'b1;
                    state_nxt_s = ARB_ISSUE;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                if (mm_req_ready) begin
                    state_nxt_s = ARB_WAIT;
                end else begin
                    state_nxt_s = ARB_ISSUE;
                end
            end
            ARB_WAIT: begin
                if (mm_rsp_valid) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_WAIT;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // Payload of the granted queue head
    always_comb begin
        if (grant_d_s) begin
            winner_s = memory_request_t'(dhead_s);
        end else begin
            winner_s = memory_request_t'(ihead_s);
        end
    end

    // Starvation counter: counts D$ grants taken while I$ waits, saturating at the limit
    always_comb begin
        if (!ivalid_s || grant_i_s) begin
            starve_nxt_s = '0;
        end else if (grant_d_s && (starve_cnt_r != STARVE_MAX)) begin
            starve_nxt_s = starve_cnt_r + STARVE_ONE;
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // FSM state, starvation counter and sticky overflow flag
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ARB_IDLE;
            starve_cnt_r   <= '0;
            overflow_error <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            starve_cnt_r   <= starve_nxt_s;
            overflow_error <= overflow_error | iovf_s | dovf_s;
        end
    end

    // Memory request port: payload latched at grant and held until the transfer
    always_ff @(posedge clock) begin
        if (reset) begin
            mm_req_valid <= 1'b0;
            mm_req_info  <= '0;
            cache_id_r   <= CACHE_ID_I;
        end else if (grant_i_s || grant_d_s) begin
            mm_req_valid <= 1'b1;
            mm_req_info  <= winner_s;
            cache_id_r   <= grant_d_s ? CACHE_ID_D : CACHE_ID_I;
        end else if ((state_r == ARB_ISSUE) && mm_req_ready) begin
            mm_req_valid <= 1'b0;
        end else begin
            mm_req_valid <= mm_req_valid;
        end
    end

    // Response to core; fields keep their last value between strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_miss <= 1'b0;
            rsp_cache_id   <= CACHE_ID_I;
            rsp_thread_id  <= '0;
            rsp_data_miss  <= '0;
            rsp_bus_error  <= 1'b0;
        end else begin
            rsp_valid_miss <= rsp_fire_s;
            if (rsp_fire_s) begin
                rsp_cache_id  <= cache_id_r;
                rsp_thread_id <= mm_req_info.thread_id;
                rsp_data_miss <= mm_rsp_data;
                rsp_bus_error <= mm_rsp_bus_error;
            end
        end
    end

endmodule
